serial_addsub: RTL
==================

# serial_addsub

Parametrised bit-serial adder/subtractor with word framing. It processes LANES independent LSB-first bit streams in lockstep, and each lane has its own carry. A word-position counter frames every WIDTH-bit word. At the last bit the block reports per-lane carry-out and signed overflow. It sits in the bit-serial arithmetic datapath, feeding serial multiplier/accumulator stages.

## Interface
- WIDTH, 8: bits per word; must be ≥ 2.
- LANES, 1: number of parallel independent serial lanes.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a bit pair is present on x/y this cycle.
- in_first  in  1  qualifies the LSB of a new word; meaningful only with in_valid.
- mode  in  1  0 = add, 1 = subtract (x − y); sampled only on an accepted first bit.
- x  in  LANES  operand A bits, one per lane.
- y  in  LANES  operand B bits, one per lane.
- sum  out  LANES  result bits, registered.
- out_valid  out  1  sum holds a valid bit.
- out_first  out  1  sum holds the LSB of a word.
- out_last  out  1  sum holds the MSB of a word; carry_out/ovf valid.
- carry_out  out  LANES  unsigned carry (add) or no-borrow (sub); valid with out_last, else 0.
- ovf  out  LANES  signed overflow; valid with out_last, else 0.
- frame_err  out  1  one-cycle pulse on a framing violation.

## Operation
- FSM states:
  - IDLE: waits for the start of a word.
  - RUN: a word is in progress.
- Each lane uses b = y ^ mode_q.
  - On the first bit, carry-in = mode (two's-complement +1 for subtract).
  - On later bits, carry-in = the lane's carry register.
  - sum = x ^ b ^ cin; carry_next = maj(x, b, cin).
- mode_q is latched on the accepted first bit and held for the whole word.
- Bit counter is $clog2(WIDTH) wide.
  - Set to 1 after the first bit.
  - Increments on each accepted bit in RUN.
  - Bit index WIDTH−1 is the last bit.
- Transitions:
  - IDLE + in_valid & in_first → RUN, counter = 1.
  - RUN + in_valid & last index → IDLE.
  - RUN + in_valid & !in_first & not last → stay in RUN, counter +1.
- in_valid low stalls: carry, counter and mode_q are held, and out_valid goes low.
- On the last bit:
  - carry_out = carry_next.
  - ovf = cin ^ carry_next at the MSB.
- Boundary conditions:
  - in_valid without in_first in IDLE: bit dropped, no output, frame_err pulses.
  - in_first while in RUN: current word abandoned with no out_last, frame_err pulses. The bit is accepted as the LSB of the new word, using the new mode.
  - Back-to-back words: the first bit of the next word is accepted in the cycle after the last bit, with no bubble.
  - rst mid-word: word discarded, FSM to IDLE. No out_last is ever produced for it.
- Reset values:
  - All outputs 0.
  - Carries 0, counter 0, mode_q 0, state IDLE.

## Timing
- Latency: 1 cycle from an accepted input bit to the matching sum/out_valid.
- out_first and out_last each pulse for exactly one cycle per word, aligned with their bits.
- frame_err is registered and asserts one cycle after the offending input.
- Sustained throughput: one bit per lane per cycle, and one word per WIDTH cycles.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined: ovf is computed per lane as above.
- Macro undefined: ovf is tied to 0 and the MSB carry-in tracking logic is removed. Sum, carry_out and framing behaviour are unchanged.

## Structure
- Package serial_pkg holds:
  - the state typedef (IDLE, RUN);
  - the mode constants MODE_ADD = 1'b0 and MODE_SUB = 1'b1.
- Sub-module serial_fa_lane, instantiated LANES times. Each instance contains:
  - the b inversion and full adder;
  - the carry register (hold on stall, seed on first);
  - the registered sum, carry_out and ovf.
- The top level holds the FSM, bit counter, mode_q and framing outputs.

## Test plan
All scenarios use WIDTH = 8 and LANES = 2 unless noted.
- Add: lane0 0x35 + 0x4A, lane1 0xFF + 0x01.
  - sum stream is 0x7F and 0x00.
  - carry_out = {1, 0}, ovf = {0, 0}.
  - out_last on the 8th output cycle.
- Signed overflow: 0x7F + 0x01 → 0x80 with ovf = 1 and carry_out = 0.
  - Repeat with SERIAL_ADDSUB_OVF_EN undefined → ovf = 0.
- Subtract (mode = 1): 0x10 − 0x20 → 0xF0 with carry_out = 0 (borrow). Also 0x20 − 0x10 → 0x10 with carry_out = 1.
- Stalls: insert 3 random in_valid-low gaps into an 0x35 + 0x4A word.
  - Result is still 0x7F; out_valid low during the gaps.
  - Back-to-back second word has no bubble.
- Framing errors:
  - in_valid without in_first in IDLE → frame_err pulses, no out_valid.
  - in_first at bit 4 → frame_err pulses; the restarted word completes correctly with one out_last.
- rst asserted at bit 5 → next cycle all outputs are 0. A following word starting in_first computes 0x01 + 0x01 = 0x02.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_fa_lane.sv
// One serial lane: operand inversion, full adder, carry register and registered results.
// Signed overflow output exists only when SERIAL_ADDSUB_OVF_EN is defined.
module serial_fa_lane
    import serial_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic accept,
    input  logic first,
    input  logic last,
    input  logic mode,
    input  logic x,
    input  logic y,
    output logic sum,
    output logic carry_out,
    output logic ovf
);

    logic b;
    logic cin;
    logic s;
    logic cn;
    logic carry_q;

    // Subtract is x + ~y + 1: the +1 enters as the seeded carry on the LSB.
    always_comb begin
        b   = y ^ (mode == MODE_SUB);
        cin = first ? (mode == MODE_SUB) : carry_q;
        s   = x ^ b ^ cin;
        cn  = (x & b) | (x & cin) | (b & cin);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q   <= 1'b0;
            sum       <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            if (accept) begin
                carry_q <= cn;
            end
            sum       <= accept & s;
            carry_out <= accept & last & cn;
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= accept & last & (cin ^ cn);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor top: word framing FSM, bit counter, mode latch and lanes.
// Define SERIAL_ADDSUB_OVF_EN to enable the per-lane signed overflow output.
module serial_addsub
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             mode,
    input  logic [LANES-1:0] x,
    input  logic [LANES-1:0] y,
    output logic [LANES-1:0] sum,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic [LANES-1:0] carry_out,
    output logic [LANES-1:0] ovf,
    output logic             frame_err
);

    localparam int unsigned     CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mode_q;
    logic          mode_eff;
    logic          take_first;
    logic          accept;
    logic          is_last;
    logic          bad_frame;

    // A first bit always starts a new word, abandoning any word in progress.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        take_first = in_valid & in_first;
        accept     = in_valid & (in_first | (state_q == RUN));
        is_last    = in_valid & ~in_first & (state_q == RUN) & (cnt_q == LAST_IDX);
        bad_frame  = in_valid & ((state_q == IDLE) ? ~in_first : in_first);
        mode_eff   = take_first ? mode : mode_q;
        if (take_first) begin
            state_d = RUN;
            cnt_d   = CW'(1);
        end else if (is_last) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mode_q    <= MODE_ADD;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take_first) begin
                mode_q <= mode;
            end
            out_valid <= accept;
            out_first <= take_first;
            out_last  <= is_last;
            frame_err <= bad_frame;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        serial_fa_lane u_lane (
            .clk       (clk),
            .rst       (rst),
            .accept    (accept),
            .first     (take_first),
            .last      (is_last),
            .mode      (mode_eff),
            .x         (x[i]),
            .y         (y[i]),
            .sum       (sum[i]),
            .carry_out (carry_out[i]),
            .ovf       (ovf[i])
        );
    end

endmodule
